// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 scancode decoder: parses press/release/extended sequences, keeps a
// live key-state bitmap and queues decoded key events in a first-word-fall-through FIFO.
//
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_data          - received scancode byte, qualified by i_data_valid (1-cycle strobe)
//   i_ready         - consumer pops the FIFO head when o_valid is also high
//   i_clear         - synchronous clear of o_keys and o_overflow
//   o_code          - FIFO head {release, 2'b00, extended, index}; 8'h00 when empty
//   o_valid         - FIFO non-empty
//   o_keys          - key-state bitmap, bit {ext, idx[2:0]} high while the key is held
//   o_overflow      - sticky, an event was dropped on a full FIFO
//   o_timeout       - one-cycle pulse when a partial sequence is abandoned
module ps2_key_event_decoder #(
    parameter int unsigned TIMEOUT_CYCLES  = 250000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter bit          SUPPRESS_REPEAT = 1'b1,
    parameter bit          REPORT_UNKNOWN  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    input  logic        i_ready,
    input  logic        i_clear,
    output logic [7:0]  o_code,
    output logic        o_valid,
    output logic [15:0] o_keys,
    output logic        o_overflow,
    output logic        o_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_REL     = 2'd2,
        S_EXT_REL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               timeout_hit;
    logic               is_ext, is_rel;
    logic               map_known;
    logic [2:0]         map_idx;
    logic               evt_emit;
    logic [7:0]         evt_code;
    logic               key_set, key_clr;
    logic [3:0]         key_bit;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [OCC_W-1:0]   occ_q;
    logic               full, push, pop;

    assign is_ext = (state_q == S_EXT) || (state_q == S_EXT_REL);
    assign is_rel = (state_q == S_REL) || (state_q == S_EXT_REL);

    // Key map lookup; the extended flag selects which table applies
    always_comb begin
        map_known = 1'b1;
        map_idx   = 3'd0;
        if (!is_ext) begin
            case (i_data)
                8'h1D:   map_idx = 3'd0;
                8'h1B:   map_idx = 3'd1;
                8'h1C:   map_idx = 3'd2;
                8'h23:   map_idx = 3'd3;
                8'h5A:   map_idx = 3'd4;
                8'h29:   map_idx = 3'd5;
                default: map_known = 1'b0;
            endcase
        end else begin
            case (i_data)
                8'h75:   map_idx = 3'd0;
                8'h72:   map_idx = 3'd1;
                8'h6B:   map_idx = 3'd2;
                8'h74:   map_idx = 3'd3;
                default: map_known = 1'b0;
            endcase
        end
    end

    // Sequence state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and event decode; E0 always restarts an extended prefix
    always_comb begin
        state_d     = state_q;
        evt_emit    = 1'b0;
        evt_code    = 8'h00;
        key_set     = 1'b0;
        key_clr     = 1'b0;
        key_bit     = {is_ext, map_idx};
        timeout_hit = (state_q != S_IDLE) && !i_data_valid &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (i_data_valid) begin
            if (i_data == 8'hE0) begin
                state_d = S_EXT;
            end else if (i_data == 8'hF0) begin
                state_d = (state_q == S_EXT) ? S_EXT_REL : S_REL;
            end else begin
                state_d = S_IDLE;
                if (map_known) begin
                    evt_code = {is_rel, 2'b00, is_ext, 1'b0, map_idx};
                    if (is_rel) begin
                        key_clr  = 1'b1;
                        evt_emit = 1'b1;
                    end else begin
                        key_set  = 1'b1;
                        evt_emit = !(SUPPRESS_REPEAT && o_keys[key_bit]);
                    end
                end else begin
                    evt_code = {is_rel, 2'b00, is_ext, 4'hF};
                    evt_emit = REPORT_UNKNOWN;
                end
            end
        end else if (timeout_hit) begin
            state_d = S_IDLE;
        end
    end

    // Inter-byte idle counter, only runs while a sequence is open
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (i_data_valid || (state_q == S_IDLE) || timeout_hit) cnt_q <= '0;
            else                                                  cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Event FIFO; a pop frees the slot for a same-cycle push when full
    assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign o_valid = (occ_q != '0);
    assign pop     = o_valid && i_ready;
    assign push    = evt_emit && (!full || pop);
    assign o_code  = o_valid ? mem_q[rd_q] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= evt_code;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Key bitmap and sticky overflow; clear wins over same-edge updates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_keys     <= '0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_keys     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (key_set)      o_keys[key_bit] <= 1'b1;
            else if (key_clr) o_keys[key_bit] <= 1'b0;
            if (evt_emit && full && !pop) o_overflow <= 1'b1;
        end
    end

endmodule
